cpu_step_ctrl: RTL and testbench
================================

CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

Interface
REQ-001 SHALL provide parameter RUN_DIV, default 1000000, BasysCLK cycles between CPU enables in run mode (legal range 2 to 2^24).
REQ-002 SHALL provide parameter SCAN_DIV, default 100000, BasysCLK cycles each display digit stays active (legal range 2 to 2^20).
REQ-003 SHALL have port BasysCLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 SHALL have port StepPulse  input  1  single-cycle step request from the button debouncer, synchronous to BasysCLK.
REQ-006 SHALL have port RunMode  input  1  slide switch, asynchronous; 1 = free-run, 0 = single-step.
REQ-007 SHALL have port Halt  input  1  CPU halted indication, synchronous to BasysCLK.
REQ-008 SHALL have port CPUEn  output  1  registered one-cycle CPU clock enable.
REQ-009 SHALL have port StepCount  output  16  registered count of CPUEn pulses issued.
REQ-010 SHALL have port AN  output  4  seven-segment anodes, active-low, one-hot-zero.
REQ-011 SHALL have port SEG  output  7  segments {g,f,e,d,c,b,a}, active-low.

Function
REQ-012 SHALL synchronize RunMode through two BasysCLK flops (RunSync); only RunSync is used by the state machine.
REQ-013 SHALL implement states STEP, RUN, HALTED; state is registered.
REQ-014 In STEP: StepPulse=1 and Halt=0 SHALL assert CPUEn on the next cycle for exactly one cycle.
REQ-015 In STEP: StepPulse=1 with Halt=1 SHALL be ignored (no CPUEn, no count).
REQ-016 In STEP: RunSync=1 SHALL transition to RUN and clear the run divider to 0; a StepPulse in that same cycle SHALL still be honoured per REQ-014.
REQ-017 In RUN: the divider SHALL increment each cycle, wrap from RUN_DIV-1 to 0, and assert CPUEn on the cycle after the divider equals RUN_DIV-1.
REQ-018 In RUN: StepPulse SHALL be ignored.
REQ-019 In RUN: Halt=1 SHALL transition to HALTED; Halt takes priority over a same-cycle divider terminal count (no CPUEn issued).
REQ-020 In RUN: RunSync=0 (with Halt=0) SHALL transition to STEP; a same-cycle terminal count SHALL not issue CPUEn.
REQ-021 In HALTED: CPUEn SHALL stay 0; StepPulse ignored; Halt deassertion SHALL not leave HALTED; RunSync=0 SHALL transition to STEP.
REQ-022 CPUEn SHALL never be high on two consecutive cycles.
REQ-023 StepCount SHALL increment by 1 in the same cycle CPUEn is high, 16-bit, wrapping 0xFFFF to 0x0000.
REQ-024 A scan counter SHALL advance the active digit index 0,1,2,3,0,... every SCAN_DIV cycles, independent of state.
REQ-025 AN[i] SHALL be 0 only for active digit i; digit i SHALL display StepCount[4i+3:4i] as hex 0-F.
REQ-026 SEG SHALL use standard hex patterns (e.g. 0 = 7'b1000000, 8 = 7'b0000000, F = 7'b0001110), registered together with AN so they change in the same cycle.

Reset
REQ-027 Reset_n=0 SHALL immediately force state STEP, CPUEn=0, StepCount=0, run divider=0, scan counter=0, digit index=0, sync flops=0, AN=4'b1110, SEG=7'b1000000.
REQ-028 Reset assertion mid-RUN or mid-CPUEn pulse SHALL terminate the pulse immediately; release SHALL be followed by normal STEP operation with no spurious CPUEn.

Verification
REQ-029 Step: RunMode=0, Halt=0, three StepPulse at cycles 10, 20, 30 -> CPUEn high at cycles 11, 21, 31 only; StepCount=3; digit 0 shows 3 (SEG=7'b0110000).
REQ-030 Run: RUN_DIV=4, RunMode=1 for 40 cycles -> CPUEn every 4th cycle, never adjacent; StepCount increases by 9 or 10 depending on sync latency, exact value checked against model.
REQ-031 Halt priority: RUN_DIV=4, assert Halt on terminal-count cycle -> no CPUEn, state HALTED; drop Halt -> still no CPUEn; RunMode=0 then StepPulse -> one CPUEn.
REQ-032 Wrap: force StepCount to 0xFFFF via 65535 steps, one more step -> StepCount=0x0000, all digits show 0.
REQ-033 Scan: SCAN_DIV=3 -> AN sequence 1110,1101,1011,0111 repeating, each held 3 cycles, SEG matching nibble of StepCount.
REQ-034 Reset mid-run: Reset_n=0 while CPUEn=1 -> CPUEn=0, StepCount=0, AN=1110 same cycle, no CPUEn for 2 cycles after release with RunMode=0.

Source files
------------

// File: rtl/cpu_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cpu_step_ctrl
// Brief   : Single-step / free-run CPU clock-enable generator with a
//           multiplexed 4-digit hex display of the issued-enable count.
// Revision: 1.0 - initial release
// ============================================================================
module cpu_step_ctrl #(
  parameter int unsigned RUN_DIV  = 1000000,
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        BasysCLK,
  input  logic        Reset_n,
  input  logic        StepPulse,
  input  logic        RunMode,
  input  logic        Halt,
  output logic        CPUEn,
  output logic [15:0] StepCount,
  output logic [3:0]  AN,
  output logic [6:0]  SEG
);

  localparam int unsigned c_DIV_W  = $clog2(RUN_DIV);
  localparam int unsigned c_SCAN_W = $clog2(SCAN_DIV);
  localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(RUN_DIV - 1);
  localparam logic [c_SCAN_W-1:0] c_SCAN_LAST = c_SCAN_W'(SCAN_DIV - 1);

  localparam logic [1:0] c_STEP   = 2'd0;
  localparam logic [1:0] c_RUN    = 2'd1;
  localparam logic [1:0] c_HALTED = 2'd2;

  logic [1:0]          state_q, state_d;
  logic                meta_q, run_sync_q;
  logic                cpuen_q, cpuen_d;
  logic [c_DIV_W-1:0]  div_q, div_d;
  logic [15:0]         count_q, count_d;
  logic [c_SCAN_W-1:0] scan_q, scan_d;
  logic [1:0]          digit_q, digit_d;
  logic [3:0]          an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                w_issue;
  logic                w_div_term;
  logic                w_scan_term;
  logic [3:0]          w_nibble;

  always_ff @(posedge BasysCLK or negedge Reset_n) begin
    if (!Reset_n) begin
      meta_q     <= 1'b0;
      run_sync_q <= 1'b0;
    end else begin
      meta_q     <= RunMode;
      run_sync_q <= meta_q;
    end
  end

  always_ff @(posedge BasysCLK or negedge Reset_n) begin
    if (!Reset_n) state_q <= c_STEP;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_STEP:   if (run_sync_q) state_d = c_RUN;
      c_RUN: begin
        if (Halt)             state_d = c_HALTED;
        else if (!run_sync_q) state_d = c_STEP;
      end
      c_HALTED: if (!run_sync_q) state_d = c_STEP;
      default:  state_d = c_STEP;
    endcase
  end

  assign w_div_term = (div_q == c_DIV_LAST);

  // Halt and a leave-run request both suppress a coincident terminal count.
  always_comb begin
    w_issue = 1'b0;
    div_d   = '0;
    case (state_q)
      c_STEP: w_issue = StepPulse & ~Halt;
      c_RUN: begin
        if (state_d == c_RUN) begin
          if (w_div_term) w_issue = 1'b1;
          else            div_d   = div_q + 1'b1;
        end
      end
      default: w_issue = 1'b0;
    endcase
    cpuen_d = w_issue & ~cpuen_q;
    count_d = count_q + {15'd0, cpuen_d};
  end

  always_ff @(posedge BasysCLK or negedge Reset_n) begin
    if (!Reset_n) begin
      cpuen_q <= 1'b0;
      div_q   <= '0;
      count_q <= 16'd0;
    end else begin
      cpuen_q <= cpuen_d;
      div_q   <= div_d;
      count_q <= count_d;
    end
  end

  assign w_scan_term = (scan_q == c_SCAN_LAST);

  // Display registers are fed from next-state values so AN/SEG track the count without lag.
  always_comb begin
    scan_d   = w_scan_term ? '0 : scan_q + 1'b1;
    digit_d  = w_scan_term ? digit_q + 2'd1 : digit_q;
    w_nibble = count_d[{digit_d, 2'b00} +: 4];
    an_d     = ~(4'b0001 << digit_d);
    case (w_nibble)
      4'h0:    seg_d = 7'b1000000;
      4'h1:    seg_d = 7'b1111001;
      4'h2:    seg_d = 7'b0100100;
      4'h3:    seg_d = 7'b0110000;
      4'h4:    seg_d = 7'b0011001;
      4'h5:    seg_d = 7'b0010010;
      4'h6:    seg_d = 7'b0000010;
      4'h7:    seg_d = 7'b1111000;
      4'h8:    seg_d = 7'b0000000;
      4'h9:    seg_d = 7'b0010000;
      4'hA:    seg_d = 7'b0001000;
      4'hB:    seg_d = 7'b0000011;
      4'hC:    seg_d = 7'b1000110;
      4'hD:    seg_d = 7'b0100001;
      4'hE:    seg_d = 7'b0000110;
      default: seg_d = 7'b0001110;
    endcase
  end

  always_ff @(posedge BasysCLK or negedge Reset_n) begin
    if (!Reset_n) begin
      scan_q  <= '0;
      digit_q <= 2'd0;
      an_q    <= 4'b1110;
      seg_q   <= 7'b1000000;
    end else begin
      scan_q  <= scan_d;
      digit_q <= digit_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign CPUEn     = cpuen_q;
  assign StepCount = count_q;
  assign AN        = an_q;
  assign SEG       = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_step_ctrl
// Brief   : Self-checking bench for cpu_step_ctrl against a cycle-count model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cpu_step_ctrl;

  localparam int RUN_DIV  = 4;
  localparam int SCAN_DIV = 3;
  localparam int M_STEP = 0, M_RUN = 1, M_HALTED = 2;

  logic        clk = 1'b0;
  logic        Reset_n, StepPulse, RunMode, Halt;
  logic        CPUEn;
  logic [15:0] StepCount;
  logic [3:0]  AN;
  logic [6:0]  SEG;

  int total = 0;
  int bad   = 0;

  // Model: mode, edges since reset release, first cycle of the current run
  int          m_mode, m_k, m_run_start;
  bit          m_en, m_rm1, m_rm2;
  logic [15:0] m_count;

  cpu_step_ctrl #(.RUN_DIV(RUN_DIV), .SCAN_DIV(SCAN_DIV)) dut (
    .BasysCLK (clk),
    .Reset_n  (Reset_n),
    .StepPulse(StepPulse),
    .RunMode  (RunMode),
    .Halt     (Halt),
    .CPUEn    (CPUEn),
    .StepCount(StepCount),
    .AN       (AN),
    .SEG      (SEG)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] t [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[v];
  endfunction

  function automatic logic [27:0] exp_vec();
    int d = (m_k / SCAN_DIV) % 4;
    logic [3:0] nib = m_count[4*d +: 4];
    logic [3:0] an  = ~(4'b0001 << d);
    return {m_en, m_count, an, hex7(nib)};
  endfunction

  function automatic logic [27:0] dut_vec();
    return {CPUEn, StepCount, AN, SEG};
  endfunction

  function automatic bit m_terminal();
    return (m_mode == M_RUN) && (((m_k - m_run_start) % RUN_DIV) == RUN_DIV - 1);
  endfunction

  task automatic model_reset();
    m_mode = M_STEP; m_k = 0; m_run_start = 0;
    m_en = 0; m_rm1 = 0; m_rm2 = 0; m_count = 16'd0;
  endtask

  // Advance the model by one edge using the currently driven inputs, then wait to the next negedge.
  task automatic clk_cycle();
    bit rsync = m_rm2;
    bit en_n  = 0;
    int mode_n = m_mode;
    if (m_mode == M_STEP) begin
      en_n = StepPulse && !Halt;
      if (rsync) begin mode_n = M_RUN; m_run_start = m_k + 1; end
    end else if (m_mode == M_RUN) begin
      if (Halt)        mode_n = M_HALTED;
      else if (!rsync) mode_n = M_STEP;
      else             en_n = m_terminal();
    end else if (!rsync) begin
      mode_n = M_STEP;
    end
    if (m_en) en_n = 0;
    m_en    = en_n;
    m_count = m_count + 16'(en_n);
    m_mode  = mode_n;
    m_k++;
    m_rm2 = m_rm1;
    m_rm1 = RunMode;
    @(negedge clk);
  endtask

  task automatic test_reset();
    Reset_n = 0; StepPulse = 0; RunMode = 0; Halt = 0;
    model_reset();
    repeat (3) @(negedge clk);
    total++;
    if (CPUEn !== 1'b0 || StepCount !== 16'd0 || AN !== 4'b1110 || SEG !== 7'b1000000) begin
      bad++;
      $display("FAIL reset_state got en=%b cnt=%h an=%b seg=%b exp en=0 cnt=0000 an=1110 seg=1000000",
               CPUEn, StepCount, AN, SEG);
    end
    Reset_n = 1;
    repeat (4) begin
      clk_cycle();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL reset_idle k=%0d got=%h exp=%h", m_k, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_step();
    logic [15:0] base = m_count;
    for (int i = 0; i < 40; i++) begin
      StepPulse = (i == 10 || i == 20 || i == 30);
      clk_cycle();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL step_model k=%0d got=%h exp=%h", m_k, dut_vec(), exp_vec());
      end
      total++;
      if (CPUEn !== (i == 10 || i == 20 || i == 30)) begin
        bad++; $display("FAIL step_pulse i=%0d got=%b exp=%b", i, CPUEn, (i == 10 || i == 20 || i == 30));
      end
    end
    StepPulse = 0;
    total++;
    if (StepCount !== base + 16'd3) begin
      bad++; $display("FAIL step_count got=%h exp=%h", StepCount, base + 16'd3);
    end
  endtask

  task automatic test_scan();
    logic [3:0] prev;
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      prev = AN;
      clk_cycle();
      found = (prev !== 4'b1110) && (AN === 4'b1110);
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL scan_align got=timeout exp=AN entering 1110");
    end
    for (int j = 0; j < 12; j++) begin
      logic [3:0] ea = ~(4'b0001 << (j / 3));
      logic [6:0] es = ((j / 3) == 0) ? 7'b0110000 : 7'b1000000;
      total++;
      if (AN !== ea || SEG !== es) begin
        bad++; $display("FAIL scan_seq j=%0d got an=%b seg=%b exp an=%b seg=%b", j, AN, SEG, ea, es);
      end
      clk_cycle();
    end
  endtask

  task automatic test_run();
    bit prev_en = 0;
    logic [15:0] base = m_count;
    RunMode = 1;
    for (int i = 0; i < 46; i++) begin
      if (i == 40) RunMode = 0;
      clk_cycle();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL run_model k=%0d got=%h exp=%h", m_k, dut_vec(), exp_vec());
      end
      total++;
      if (prev_en && CPUEn) begin
        bad++; $display("FAIL run_adjacent k=%0d got=1 exp=0", m_k);
      end
      prev_en = CPUEn;
    end
    total++;
    if (StepCount - base != 16'd9 && StepCount - base != 16'd10) begin
      bad++; $display("FAIL run_delta got=%0d exp=9or10", StepCount - base);
    end
  endtask

  task automatic test_halt_priority();
    bit found = 0;
    RunMode = 1;
    for (int i = 0; i < 30 && !found; i++) begin
      if (m_terminal()) found = 1;
      else clk_cycle();
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL halt_find got=timeout exp=terminal count");
    end
    Halt = 1;
    clk_cycle();
    total++;
    if (CPUEn !== 1'b0 || dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL halt_on_tc got=%h exp=%h", dut_vec(), exp_vec());
    end
    Halt = 0;
    for (int i = 0; i < 12; i++) begin
      clk_cycle();
      total++;
      if (CPUEn !== 1'b0 || dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL halt_hold i=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
    RunMode = 0;
    repeat (4) clk_cycle();
    StepPulse = 1;
    clk_cycle();
    StepPulse = 0;
    total++;
    if (CPUEn !== 1'b1 || dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL halt_exit_step got=%h exp=%h", dut_vec(), exp_vec());
    end
    clk_cycle();
    total++;
    if (CPUEn !== 1'b0) begin
      bad++; $display("FAIL halt_exit_single got=%b exp=0", CPUEn);
    end
  endtask

  // Preload to 0xFFFE rather than walking 65534 steps (each costs at least two cycles).
  task automatic test_wrap();
    repeat (3) clk_cycle();
    force dut.count_q = 16'hFFFE;
    m_count = 16'hFFFE;
    clk_cycle();
    release dut.count_q;
    for (int s = 0; s < 2; s++) begin
      StepPulse = 1;
      clk_cycle();
      StepPulse = 0;
      total++;
      if (StepCount !== ((s == 0) ? 16'hFFFF : 16'h0000)) begin
        bad++; $display("FAIL wrap_count s=%0d got=%h exp=%h", s, StepCount, (s == 0) ? 16'hFFFF : 16'h0000);
      end
      for (int i = 0; i < 12; i++) begin
        total++;
        if (dut_vec() !== exp_vec() || SEG !== ((s == 0) ? 7'b0001110 : 7'b1000000)) begin
          bad++; $display("FAIL wrap_digits s=%0d i=%0d got=%h exp=%h", s, i, dut_vec(), exp_vec());
        end
        clk_cycle();
      end
    end
  endtask

  task automatic test_random();
    bit prev_en = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) RunMode = ~RunMode;
      if ($urandom_range(0, 29) == 0) Halt = ~Halt;
      StepPulse = !StepPulse && ($urandom_range(0, 4) == 0);
      clk_cycle();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL random_model k=%0d got=%h exp=%h", m_k, dut_vec(), exp_vec());
      end
      total++;
      if (prev_en && CPUEn) begin
        bad++; $display("FAIL random_adjacent k=%0d got=1 exp=0", m_k);
      end
      prev_en = CPUEn;
    end
    RunMode = 0; Halt = 0; StepPulse = 0;
    repeat (6) begin
      clk_cycle();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL random_settle k=%0d got=%h exp=%h", m_k, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid_run();
    bit found = 0;
    RunMode = 1;
    for (int i = 0; i < 30 && !found; i++) begin
      clk_cycle();
      found = m_en;
    end
    total++;
    if (!found || CPUEn !== 1'b1) begin
      bad++; $display("FAIL rst_run_pulse got=%b exp=1", CPUEn);
    end
    #2;
    Reset_n = 0;
    RunMode = 0;
    #1;
    model_reset();
    total++;
    if (CPUEn !== 1'b0 || StepCount !== 16'd0 || AN !== 4'b1110 || SEG !== 7'b1000000) begin
      bad++;
      $display("FAIL rst_immediate got en=%b cnt=%h an=%b seg=%b exp en=0 cnt=0000 an=1110 seg=1000000",
               CPUEn, StepCount, AN, SEG);
    end
    repeat (2) @(negedge clk);
    Reset_n = 1;
    for (int i = 0; i < 4; i++) begin
      clk_cycle();
      total++;
      if (CPUEn !== 1'b0 || dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL rst_release i=%0d got=%h exp=%h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_scan();
    test_run();
    test_halt_priority();
    test_wrap();
    test_random();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
